// File: rtl/weight_packer_pkg.sv
// Shared constants, state encoding and beat-count helper for the weight packer.
// Imported by weight_packer and weight_sat_step.
package weight_packer_pkg;

  localparam int WEIGHT_W  = 9;
  localparam int WORD_W    = 256;
  localparam int BUF_W     = 1280;
  localparam int MAX_BEATS = 5;

  localparam logic signed [WEIGHT_W-1:0] WMAX = 9'sh0FF;  // +255
  localparam logic signed [WEIGHT_W-1:0] WMIN = 9'sh100;  // -256

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Number of 256-bit words needed to cover n_clauses packed weights.
  function automatic logic [2:0] calc_nbeats(input int n_clauses);
    int bits;
    int beats;
    bits  = n_clauses * WEIGHT_W;
    beats = (bits + WORD_W - 1) / WORD_W;
    if (beats > MAX_BEATS) beats = MAX_BEATS;
    return 3'(beats);
  endfunction

endpackage

// File: rtl/weight_sat_step.sv
// Saturating +1/-1 step on a signed 9-bit weight; inc and dec together cancel.
module weight_sat_step
  import weight_packer_pkg::*;
(
  input  logic signed [WEIGHT_W-1:0] w_i,
  input  logic                       inc_i,
  input  logic                       dec_i,
  output logic signed [WEIGHT_W-1:0] w_o
);

  always_comb begin
    w_o = w_i;
    if (inc_i && !dec_i && (w_i != WMAX)) begin
      w_o = w_i + 9'sd1;
    end else if (dec_i && !inc_i && (w_i != WMIN)) begin
      w_o = w_i - 9'sd1;
    end
  end

endmodule

// File: rtl/weight_packer.sv
// Holds the packed clause-weight image, applies init/saturating updates and
// streams the image as 256-bit words to the weight-store write port.
module weight_packer
  import weight_packer_pkg::*;
#(
  parameter  int CLAUSEN = 10,
  localparam int CW      = $clog2(CLAUSEN) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW-1:0]       clauses,
  input  logic                init,
  input  logic [WEIGHT_W-1:0] init_value,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [CW-1:0]       upd_clause,
  input  logic                upd_inc,
  input  logic                upd_dec,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic [2:0]          out_offset,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                dbg_state
);

  // Update handshake: a request completes on any cycle with upd_valid && upd_ready;
  // upd_ready is high exactly in IDLE. Out beats complete on out_valid && out_ready,
  // and the payload is held unchanged until that happens.

  state_e              state_q, state_d;
  logic [BUF_W-1:0]    image_q, image_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          nbeats_q, nbeats_d;
  logic                done_q, done_d;

  logic [CW-1:0]              slot_pos;
  logic [10:0]                slot_base;
  logic                       upd_hit;
  logic signed [WEIGHT_W-1:0] cur_w;
  logic signed [WEIGHT_W-1:0] new_w;

  assign upd_ready = (state_q == IDLE);
  assign busy      = (state_q == STREAM);
  assign out_valid = (state_q == STREAM);
  assign done      = done_q;
  assign dbg_state = state_q;

  // Clause k sits at slot position clauses-k-1 counted from the image LSB.
  assign slot_pos  = clauses - upd_clause - CW'(1);
  assign upd_hit   = upd_valid && upd_ready && !init && (upd_clause < clauses);
  assign slot_base = upd_hit ? (11'(slot_pos) * 11'(WEIGHT_W)) : 11'd0;
  assign cur_w     = image_q[slot_base +: WEIGHT_W];

  weight_sat_step u_sat (
    .w_i   (cur_w),
    .inc_i (upd_inc),
    .dec_i (upd_dec),
    .w_o   (new_w)
  );

  always_comb begin
    image_d = image_q;
    if (state_q == IDLE) begin
      if (init) begin
        for (int j = 0; j < CLAUSEN; j++) begin
          if (j < int'(clauses)) image_d[j*WEIGHT_W +: WEIGHT_W] = init_value;
        end
      end else if (upd_hit) begin
        image_d[slot_base +: WEIGHT_W] = new_w;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nbeats_d = nbeats_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          nbeats_d = calc_nbeats(int'(clauses));
          cnt_d    = 3'd0;
          if (nbeats_d == 3'd0) done_d = 1'b1;
          else                  state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (cnt_q == nbeats_q - 3'd1) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data   = '0;
    out_offset = 3'd0;
    out_last   = 1'b0;
    if (state_q == STREAM) begin
      out_data   = image_q[{cnt_q, 8'd0} +: WORD_W];
      out_offset = cnt_q;
      out_last   = (cnt_q == nbeats_q - 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      image_q  <= '0;
      cnt_q    <= 3'd0;
      nbeats_q <= 3'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      image_q  <= image_d;
      cnt_q    <= cnt_d;
      nbeats_q <= nbeats_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_weight_packer.sv
// Self-checking bench for weight_packer: random and directed traffic against
// an image-level reference model of the packed clause weights.
module tb_weight_packer;

  logic         clk;
  logic         rst;
  logic [6:0]   clauses;
  logic         init;
  logic [8:0]   init_value;
  logic         upd_valid;
  logic         upd_ready;
  logic [6:0]   upd_clause;
  logic         upd_inc;
  logic         upd_dec;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic [2:0]   out_offset;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1279:0] m_img;
  logic [255:0]  beat0_seen;

  weight_packer #(.CLAUSEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .clauses    (clauses),
    .init       (init),
    .init_value (init_value),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_clause (upd_clause),
    .upd_inc    (upd_inc),
    .upd_dec    (upd_dec),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_offset (out_offset),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic void m_init(input logic [8:0] v);
    int c;
    c = int'(clauses);
    for (int k = 0; k < c; k++) m_img[(c-k-1)*9 +: 9] = v;
  endfunction

  function automatic void m_upd(input int k, input bit inc, input bit dec);
    int c;
    int v;
    logic signed [8:0] s;
    c = int'(clauses);
    if (k >= c) return;
    s = m_img[(c-k-1)*9 +: 9];
    v = s;
    v = v + (inc ? 1 : 0) - (dec ? 1 : 0);
    if (v > 255)  v = 255;
    if (v < -256) v = -256;
    m_img[(c-k-1)*9 +: 9] = 9'(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_op(input bit do_init, input logic [8:0] iv, input bit do_upd,
                       input int k, input bit inc, input bit dec);
    init       = do_init;
    init_value = iv;
    upd_valid  = do_upd;
    upd_clause = 7'(k);
    upd_inc    = inc;
    upd_dec    = dec;
    if (do_upd) begin
      n_checks++;
      if (upd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL op_upd_ready: got %b want 1", upd_ready);
      end
    end
    tick();
    init = 1'b0; upd_valid = 1'b0; upd_inc = 1'b0; upd_dec = 1'b0;
    if (do_init)     m_init(iv);
    else if (do_upd) m_upd(k, inc, dec);
  endtask

  // Pulse flush (optionally with a same-cycle inc), then consume and check every beat.
  // hold_upd keeps an inc request on clause hk pending throughout the stream.
  task automatic run_flush(input string name, input bit stall, input bit pre_upd,
                           input int pk, input bit hold_upd, input int hk);
    logic [255:0] exp_q[$];
    logic [255:0] popped;
    int nb;
    int beat;
    int cyc;
    if (pre_upd) begin
      upd_valid = 1'b1; upd_clause = 7'(pk); upd_inc = 1'b1;
      n_checks++;
      if (upd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s pre_upd_ready: got %b want 1", name, upd_ready);
      end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if (pre_upd) begin
      upd_valid = 1'b0; upd_inc = 1'b0;
      m_upd(pk, 1'b1, 1'b0);
    end
    nb = (int'(clauses) * 9 + 255) / 256;
    for (int b = 0; b < nb; b++) exp_q.push_back(m_img[b*256 +: 256]);
    if (hold_upd) begin
      upd_valid = 1'b1; upd_clause = 7'(hk); upd_inc = 1'b1;
    end
    beat = 0;
    cyc  = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      out_ready = stall ? 1'(cyc % 2) : 1'b1;
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s ctrl beat %0d: got valid=%b busy=%b done=%b want 1 1 0",
                 name, beat, out_valid, busy, done);
      end
      n_checks++;
      if (out_offset !== 3'(beat) || out_last !== (exp_q.size() == 1)) begin
        n_fail++;
        $display("FAIL %s tag beat %0d: got offset=%0d last=%b want %0d %b",
                 name, beat, out_offset, out_last, beat, (exp_q.size() == 1));
      end
      n_checks++;
      if (out_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL %s data beat %0d: got %h want %h", name, beat, out_data, exp_q[0]);
      end
      if (hold_upd) begin
        n_checks++;
        if (upd_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s upd_ready_stream: got %b want 0", name, upd_ready);
        end
      end
      if (beat == 0) beat0_seen = out_data;
      tick();
      cyc++;
      if (out_ready) begin
        popped = exp_q.pop_front();
        beat++;
      end
    end
    out_ready = 1'b1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got %0d beats want %0d", name, beat, nb);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_cycle: got done=%b busy=%b valid=%b want 1 0 0",
               name, done, busy, out_valid);
    end
    if (hold_upd) begin
      n_checks++;
      if (upd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s upd_ready_done: got %b want 1", name, upd_ready);
      end
    end
    tick();
    if (hold_upd) begin
      upd_valid = 1'b0; upd_inc = 1'b0;
      m_upd(hk, 1'b1, 1'b0);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_once: got %b want 0", name, done);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    m_img = '0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: got valid=%b busy=%b done=%b rdy=%b want 0 0 0 1",
               out_valid, busy, done, upd_ready);
    end
    n_checks++;
    if (out_data !== 256'd0 || out_offset !== 3'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got data=%h off=%0d last=%b want 0 0 0",
               out_data, out_offset, out_last);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_init_flush();
    logic [89:0] exp_ones;
    exp_ones = {10{9'h001}};
    clauses = 7'd10;
    do_op(1'b1, 9'h001, 1'b0, 0, 1'b0, 1'b0);
    run_flush("init_flush", 1'b0, 1'b0, 0, 1'b0, 0);
    n_checks++;
    if (beat0_seen[89:0] !== exp_ones || beat0_seen[255:90] !== '0) begin
      n_fail++;
      $display("FAIL init_flush_const: got %h want %h", beat0_seen, {166'd0, exp_ones});
    end
  endtask

  task automatic test_updates();
    for (int i = 0; i < 3; i++) do_op(1'b0, 9'h0, 1'b1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) do_op(1'b0, 9'h0, 1'b1, 9, 1'b0, 1'b1);
    do_op(1'b0, 9'h0, 1'b1, 12, 1'b1, 1'b0);
    run_flush("updates", 1'b0, 1'b0, 0, 1'b0, 0);
    n_checks++;
    if (beat0_seen[89:81] !== 9'h004 || beat0_seen[8:0] !== 9'h1FF) begin
      n_fail++;
      $display("FAIL updates_const: got hi=%h lo=%h want 004 1ff",
               beat0_seen[89:81], beat0_seen[8:0]);
    end
  endtask

  task automatic test_saturation();
    clauses = 7'd10;
    do_op(1'b1, 9'h0FF, 1'b0, 0, 1'b0, 1'b0);
    do_op(1'b0, 9'h0, 1'b1, 3, 1'b1, 1'b0);
    run_flush("sat_max", 1'b0, 1'b0, 0, 1'b0, 0);
    n_checks++;
    if (beat0_seen[62:54] !== 9'h0FF) begin
      n_fail++;
      $display("FAIL sat_max_const: got %h want 0ff", beat0_seen[62:54]);
    end
    do_op(1'b1, 9'h100, 1'b0, 0, 1'b0, 1'b0);
    do_op(1'b0, 9'h0, 1'b1, 3, 1'b0, 1'b1);
    run_flush("sat_min", 1'b0, 1'b0, 0, 1'b0, 0);
    n_checks++;
    if (beat0_seen[62:54] !== 9'h100) begin
      n_fail++;
      $display("FAIL sat_min_const: got %h want 100", beat0_seen[62:54]);
    end
    do_op(1'b1, 9'h005, 1'b0, 0, 1'b0, 1'b0);
    do_op(1'b0, 9'h0, 1'b1, 3, 1'b1, 1'b1);
    do_op(1'b1, 9'h007, 1'b1, 4, 1'b1, 1'b0);
    run_flush("inc_dec_cancel", 1'b0, 1'b0, 0, 1'b0, 0);
    n_checks++;
    if (beat0_seen[62:54] !== 9'h007 || beat0_seen[53:45] !== 9'h007) begin
      n_fail++;
      $display("FAIL inc_dec_const: got %h %h want 007 007",
               beat0_seen[62:54], beat0_seen[53:45]);
    end
  endtask

  task automatic test_stall_stream();
    clauses = 7'd60;
    do_op(1'b1, 9'($urandom_range(0, 511)), 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      do_op(1'b0, 9'h0, 1'b1, $urandom_range(0, 59), 1'($urandom), 1'($urandom));
    run_flush("stall_stream", 1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_upd_during_stream();
    clauses = 7'd60;
    run_flush("hold_upd", 1'b1, 1'b0, 0, 1'b1, 5);
    run_flush("hold_upd_after", 1'b0, 1'b0, 0, 1'b0, 0);
    run_flush("flush_with_upd", 1'b0, 1'b1, 2, 1'b0, 0);
  endtask

  task automatic test_reset_mid_stream();
    clauses = 7'd60;
    do_op(1'b1, 9'h0AB, 1'b0, 0, 1'b0, 1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_offset !== 3'd1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got valid=%b off=%0d want 1 1", out_valid, out_offset);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_img = '0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_post: got valid=%b busy=%b done=%b want 0 0 0",
               out_valid, busy, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_nodone: got %b want 0", done);
    end
    run_flush("post_rst_flush", 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_zero_clauses();
    clauses = 7'd0;
    do_op(1'b0, 9'h0, 1'b1, 0, 1'b1, 1'b0);
    run_flush("zero_clauses", 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    int c;
    for (int r = 0; r < 6; r++) begin
      c = $urandom_range(1, 64);
      clauses = 7'(c);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 7) == 0)
          do_op(1'b1, 9'($urandom_range(0, 511)), 1'($urandom), $urandom_range(0, c - 1),
                1'b1, 1'b0);
        else
          do_op(1'b0, 9'h0, 1'b1, $urandom_range(0, c + 2), 1'($urandom), 1'($urandom));
      end
      run_flush("random", 1'($urandom), 1'b0, 0, 1'b0, 0);
    end
  endtask

  initial begin
    rst = 1'b1; clauses = 7'd0; init = 1'b0; init_value = 9'h0;
    upd_valid = 1'b0; upd_clause = 7'd0; upd_inc = 1'b0; upd_dec = 1'b0;
    flush = 1'b0; out_ready = 1'b1; m_img = '0; beat0_seen = '0;
    test_reset();
    test_init_flush();
    test_updates();
    test_saturation();
    test_stall_stream();
    test_upd_during_stream();
    test_reset_mid_stream();
    test_zero_clauses();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_packer.md
# weight_packer

Transmit-side companion to the clause-weight store. Holds the signed 9-bit clause weights in a 1280-bit image and applies saturating ±1 training updates or bulk initialisation to them. On request, streams the image as 256-bit words tagged with a 3-bit word offset, in the same packed layout the weight store consumes. It sits between the training/update logic and the weight-store write port.

## Interface
- CLAUSEN, 10, number of clause slots supported; must satisfy CLAUSEN*9 <= 1280.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- clauses  in  $clog2(CLAUSEN)+1  active clause count; static while busy=1.
- init  in  1  one-cycle pulse: write init_value to slots 0..clauses-1.
- init_value  in  9  signed initial weight.
- upd_valid  in  1  update request.
- upd_ready  out  1  update accepted when upd_valid&upd_ready.
- upd_clause  in  $clog2(CLAUSEN)+1  clause index k of update.
- upd_inc  in  1  +1 (saturating).
- upd_dec  in  1  -1 (saturating); inc&dec together = no change.
- flush  in  1  one-cycle pulse: stream current image.
- out_valid  out  1  beat valid.
- out_ready  in  1  sink accepts beat.
- out_data  out  256  beat payload.
- out_offset  out  3  word offset of beat (0..4).
- out_last  out  1  final beat of flush.
- busy  out  1  streaming in progress.
- done  out  1  one-cycle pulse after final beat handshake.

## Operation
- Layout: clause k occupies image bits [(clauses-k-1)*9 +: 9], two's complement; beat b carries image bits [b*256 +: 256].
- Image bits not belonging to slots 0..clauses-1 are written 0 by reset and are never modified by init or updates.
- FSM states: IDLE, STREAM.
- IDLE:
  - upd_ready=1.
  - init has priority over an update in the same cycle; the update is still handshaken and is dropped.
  - Update with upd_clause >= clauses is accepted with no effect.
  - flush: nbeats = ceil(clauses*9/256), latched. If nbeats=0, pulse done next cycle and stay IDLE; otherwise go to STREAM with beat counter 0.
  - init or update in the same cycle as flush is applied first, so the stream reflects it.
- STREAM:
  - busy=1, upd_ready=0, image frozen; init and flush are ignored.
  - out_valid=1, out_offset=beat counter, out_data=beat slice, out_last = (counter==nbeats-1).
  - On handshake, counter increments. On the last handshake, return to IDLE and pulse done in the following cycle.
- Saturation: +1 at 255 holds 255; -1 at -256 holds -256.
- Reset values: image all 0, state IDLE, out_valid 0, out_offset 0, out_last 0, out_data 0, busy 0, done 0, upd_ready 1.

## Timing
- Update and init: the new slot value is visible at the next clock edge (1-cycle read-modify-write).
- Flush to first out_valid: 1 cycle.
- Back-to-back beats at 1 per cycle when out_ready=1.
- out_data, out_offset and out_last are held stable while out_valid=1 and out_ready=0.
- done is asserted 1 cycle after the final handshake; busy is low in that same cycle; a new flush is accepted in that cycle.
- rst mid-stream: out_valid=0 and the image is cleared at the next edge; no done pulse.

## Structure
- Shared package contains:
  - WEIGHT_W=9, WORD_W=256, BUF_W=1280, MAX_BEATS=5.
  - Saturation bounds WMAX=255, WMIN=-256.
  - State enum {IDLE, STREAM}.
- Sub-module weight_sat_step: 9-bit signed in, inc/dec in, saturated 9-bit out. Instantiated once on the update path.

## Test plan
- Reset, clauses=10, init_value=1, flush with out_ready=1 -> one beat, offset 0, out_data[89:0] = ten copies of 9'h001, bits 255:90 = 0, out_last=1, done one cycle later.
- From the state above, upd_inc on clause 0 three times, then upd_dec on clause 9 twice -> bits 89:81 = 9'h004, bits 8:0 = 9'h1FF.
- init_value=255 then inc on clause 3 -> slot stays 255; init_value=-256 (9'h100) then dec -> slot stays 9'h100; inc&dec together -> unchanged.
- clauses=60, out_ready toggling 1/0 -> 3 beats at offsets 0,1,2; payload stable while stalled; out_last only on offset 2; done once.
- upd_valid held during STREAM -> upd_ready=0 until done cycle, then the update applies; flush+upd_inc on clause 2 in the same IDLE cycle -> streamed slot includes the increment.
- rst asserted on the second beat of a 3-beat stream -> out_valid=0, busy=0 next cycle; subsequent flush streams an all-zero image.
